// File: rtl/regfile_wb_arbiter.sv
// Purpose: two-port writeback arbiter sharing the register file's single write port (ALU = port 0, load = port 1).
// Latency: a request sampled in IDLE drives storeNow on the next cycle; at most one write completes every 3 cycles.
// Backpressure: requests are held until ack; writes stall on storeDone and abort after TIMEOUT cycles, setting sticky err.
// Build option: define WB_ARB_FIXED_PRIO_EN so port 1 always wins contention; the default is round robin.
module regfile_wb_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [3:0]  dest0,
    input  logic [15:0] val0,
    output logic        ack0,
    input  logic        req1,
    input  logic [3:0]  dest1,
    input  logic [15:0] val1,
    output logic        ack1,
    output logic [3:0]  destReg,
    output logic [15:0] destVal,
    output logic        storeNow,
    input  logic        storeDone,
    output logic        busy,
    output logic        lastGrant,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t           state;
    logic             grant;
    logic [CNT_W-1:0] cnt;
    logic             pickValid;
    logic             pick;

    // Choose the winner among pending requests; only consumed in IDLE.
    always_comb begin
        pickValid = req0 | req1;
        pick      = 1'b0;
        if (req0 && req1) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            pick = 1'b1;
`else
            pick = ~lastGrant;
`endif
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Control FSM: every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= 1'b0;
            cnt       <= '0;
            storeNow  <= 1'b0;
            destReg   <= '0;
            destVal   <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            busy      <= 1'b0;
            lastGrant <= 1'b1;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (pickValid) begin
                        grant    <= pick;
                        destReg  <= pick ? dest1 : dest0;
                        destVal  <= pick ? val1 : val0;
                        storeNow <= 1'b1;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (storeDone) begin
                        storeNow  <= 1'b0;
                        ack0      <= ~grant;
                        ack1      <= grant;
                        lastGrant <= grant;
                        state     <= ACK;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Abort without ack; the held request is retried from IDLE.
                        storeNow <= 1'b0;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    // Dead cycle so the requester can drop req before the next arbitration.
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    storeNow <= 1'b0;
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a driver issues requests and queues the expected
// writes; a negedge monitor pops and checks each completed write when an ack appears.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  dest0 = '0, dest1 = '0;
    logic [15:0] val0 = '0, val1 = '0;
    logic        storeDone = 1'b0;
    logic        ack0, ack1, storeNow, busy, lastGrant, err;
    logic [3:0]  destReg;
    logic [15:0] destVal;

    regfile_wb_arbiter #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .dest0(dest0), .val0(val0), .ack0(ack0),
        .req1(req1), .dest1(dest1), .val1(val1), .ack1(ack1),
        .destReg(destReg), .destVal(destVal), .storeNow(storeNow),
        .storeDone(storeDone), .busy(busy), .lastGrant(lastGrant), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic [3:0]  d;
        logic [15:0] v;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;
    int   ackCnt0 = 0, ackCnt1 = 0, strobeCnt = 0;
    logic storePrev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitAck(input logic port, input int budget);
        int n = 0;
        while (!(port ? ack1 : ack0) && n < budget) begin
            tick();
            n++;
        end
        check(port ? "wait ack1" : "wait ack0", {31'd0, (port ? ack1 : ack0)}, 32'd1);
    endtask

    // Monitor: every ack must match the oldest queued write.
    always @(negedge clk) begin
        exp_t e;
        if (storeNow && !storePrev) strobeCnt++;
        storePrev = storeNow;
        if (ack0) ackCnt0++;
        if (ack1) ackCnt1++;
        if (ack0 || ack1) begin
            check("ack exclusive", {30'd0, ack1, ack0} & 32'h3, ack1 ? 32'h2 : 32'h1);
            if (expQ.size() == 0) begin
                check("unexpected ack", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                check("sb port", {31'd0, ack1}, {31'd0, e.port});
                check("sb destReg", {28'd0, destReg}, {28'd0, e.d});
                check("sb destVal", {16'd0, destVal}, {16'd0, e.v});
            end
        end
    end

    task automatic doReset();
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        storeDone = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n, s0, a0, a1;
        // Reset values
        tick();
        tick();
        check("rst storeNow", {31'd0, storeNow}, 32'd0);
        check("rst destReg", {28'd0, destReg}, 32'd0);
        check("rst destVal", {16'd0, destVal}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst lastGrant", {31'd0, lastGrant}, 32'd1);
        check("rst err", {31'd0, err}, 32'd0);
        check("rst acks", {30'd0, ack1, ack0}, 32'd0);
        rst = 1'b0;

        // 1: single request, storeDone after two WRITE cycles
        req0 = 1'b1; dest0 = 4'd3; val0 = 16'h0100;
        expQ.push_back('{1'b0, 4'd3, 16'h0100});
        tick();
        check("t1 storeNow", {31'd0, storeNow}, 32'd1);
        check("t1 destReg", {28'd0, destReg}, 32'd3);
        check("t1 destVal", {16'd0, destVal}, 32'h0100);
        check("t1 busy", {31'd0, busy}, 32'd1);
        tick();
        check("t1 hold storeNow", {31'd0, storeNow}, 32'd1);
        storeDone = 1'b1;
        tick();
        check("t1 ack0", {31'd0, ack0}, 32'd1);
        check("t1 storeNow off", {31'd0, storeNow}, 32'd0);
        req0 = 1'b0;
        storeDone = 1'b0;
        tick();
        check("t1 ack0 cleared", {31'd0, ack0}, 32'd0);
        check("t1 idle busy", {31'd0, busy}, 32'd0);
        check("t1 lastGrant", {31'd0, lastGrant}, 32'd0);
        tick();
        check("t1 ack0 count", ackCnt0, 32'd1);

        // 2: contention, round robin, one write per 3 cycles
        doReset();
        s0 = strobeCnt;
        req0 = 1'b1; dest0 = 4'd2; val0 = 16'h0080;
        req1 = 1'b1; dest1 = 4'd5; val1 = 16'h1234;
        storeDone = 1'b1;
`ifdef WB_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) expQ.push_back('{1'b1, 4'd5, 16'h1234});
`else
        for (int k = 0; k < 4; k++)
            expQ.push_back((k % 2 == 0) ? exp_t'({1'b0, 4'd2, 16'h0080}) : exp_t'({1'b1, 4'd5, 16'h1234}));
`endif
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef WB_ARB_FIXED_PRIO_EN
            check("t2 ack pattern", {30'd0, ack1, ack0}, 32'h2);
`else
            check("t2 ack pattern", {30'd0, ack1, ack0}, (k % 2 == 0) ? 32'h1 : 32'h2);
`endif
            if (k < 3) begin
                tick();
                tick();
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        check("t2 strobes", strobeCnt - s0, 32'd4);
        check("t2 lastGrant", {31'd0, lastGrant}, 32'd1);
        check("t2 idle busy", {31'd0, busy}, 32'd0);

        // 3: no double write when req0 drops right after ack0
        doReset();
        s0 = strobeCnt; a0 = ackCnt0; a1 = ackCnt1;
        req0 = 1'b1; dest0 = 4'd7; val0 = 16'hABCD;
        storeDone = 1'b1;
        expQ.push_back('{1'b0, 4'd7, 16'hABCD});
        waitAck(1'b0, 20);
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t3 one strobe", strobeCnt - s0, 32'd1);
        check("t3 one ack0", ackCnt0 - a0, 32'd1);
        check("t3 no ack1", ackCnt1 - a1, 32'd0);

        // 4: timeout after 15 WRITE cycles, then retry succeeds
        doReset();
        a1 = ackCnt1;
        storeDone = 1'b0;
        req1 = 1'b1; dest1 = 4'd9; val1 = 16'h5A5A;
        expQ.push_back('{1'b1, 4'd9, 16'h5A5A});
        tick();
        n = 0;
        while (storeNow && n < 40) begin
            n++;
            tick();
        end
        check("t4 write cycles", n, 32'd15);
        check("t4 err", {31'd0, err}, 32'd1);
        check("t4 no ack1", ackCnt1 - a1, 32'd0);
        check("t4 idle busy", {31'd0, busy}, 32'd0);
        storeDone = 1'b1;
        waitAck(1'b1, 20);
        req1 = 1'b0;
        tick();
        tick();
        check("t4 retry ack1", ackCnt1 - a1, 32'd1);
        check("t4 err sticky", {31'd0, err}, 32'd1);

        // 5: reset mid-write drops the write and clears err
        a0 = ackCnt0;
        storeDone = 1'b0;
        req0 = 1'b1; dest0 = 4'd1; val0 = 16'h0F0F;
        expQ.push_back('{1'b0, 4'd1, 16'h0F0F});
        tick();
        check("t5 storeNow", {31'd0, storeNow}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("t5 rst storeNow", {31'd0, storeNow}, 32'd0);
        check("t5 rst busy", {31'd0, busy}, 32'd0);
        check("t5 rst err", {31'd0, err}, 32'd0);
        check("t5 rst no ack", ackCnt0 - a0, 32'd0);
        rst = 1'b0;
        storeDone = 1'b1;
        waitAck(1'b0, 20);
        req0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t5 single ack0", ackCnt0 - a0, 32'd1);

`ifdef WB_ARB_FIXED_PRIO_EN
        // 6: fixed priority, port 1 starves port 0 until req1 drops
        doReset();
        a0 = ackCnt0; a1 = ackCnt1;
        storeDone = 1'b1;
        req0 = 1'b1; dest0 = 4'd4; val0 = 16'h0044;
        req1 = 1'b1; dest1 = 4'd8; val1 = 16'h0088;
        for (int k = 0; k < 3; k++) expQ.push_back('{1'b1, 4'd8, 16'h0088});
        expQ.push_back('{1'b0, 4'd4, 16'h0044});
        for (int k = 0; k < 3; k++) begin
            waitAck(1'b1, 20);
            if (k < 2) tick();
        end
        check("t6 no ack0 yet", ackCnt0 - a0, 32'd0);
        req1 = 1'b0;
        waitAck(1'b0, 20);
        req0 = 1'b0;
        tick();
        tick();
        check("t6 ack1 count", ackCnt1 - a1, 32'd3);
        check("t6 ack0 count", ackCnt0 - a0, 32'd1);
`endif

        tick();
        check("queue drained", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout actual=running required=finished");
        $fatal(1, "bench did not terminate");
    end

endmodule
